// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   ps2_state_e      : host-transmit FSM state encoding
//   FRAME_BITS       : bits held in the transmit shift register (start, D0..D7, parity)
//   inhibit_cycles() : clock-inhibit length in clk cycles for a given clock/us
//   timeout_cycles() : frame abort limit in clk cycles for a given clock/ms
//   INHIBIT_CYC, TIMEOUT_CYC : the above evaluated at the default 50 MHz clock
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_BITS,
    ST_ACK,
    ST_WAITREL,
    ST_DONE,
    ST_ERR
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
    longint unsigned c;
    c = 64'(clk_hz) * 64'(us) / 64'd1_000_000;
    return c[31:0];
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
    longint unsigned c;
    c = 64'(clk_hz) / 64'd1000 * 64'(ms);
    return c[31:0];
  endfunction

  localparam int unsigned DEF_CLK_HZ  = 50_000_000;
  localparam int unsigned INHIBIT_CYC = inhibit_cycles(DEF_CLK_HZ, 100);
  localparam int unsigned TIMEOUT_CYC = timeout_cycles(DEF_CLK_HZ, 15);

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw open-collector PS/2 line.
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset (line assumed idle-high)
//   line_i  in  raw asynchronous pin level
//   level_o out filtered level (changes only after FILTER stable cycles)
//   fall_o  out one-cycle strobe, high on the cycle level_o goes 1->0
module ps2_line_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      // cnt_q counts consecutive cycles the synced line disagrees with level_q
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER - 1)) begin
        level_q <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//   clk50       in  system clock
//   reset       in  synchronous active-high reset
//   tx_data     in  command byte, captured when tx_start is accepted
//   tx_start    in  one-cycle request, accepted only in IDLE
//   tx_busy     out frame in progress
//   tx_done     out one-cycle pulse: frame sent and ACK seen
//   tx_err      out one-cycle pulse: missing ACK or timeout
//   rx_hold     out copy of tx_busy for the neighbouring receiver
//   ps2_clk_i   in  raw ps2_clk pin
//   ps2_data_i  in  raw ps2_data pin
//   ps2_clk_oe  out 1 = pull ps2_clk low
//   ps2_data_oe out 1 = pull ps2_data low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15,
  parameter int unsigned FILTER     = 8
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_hold,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_CYC = inhibit_cycles(CLK_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC  = timeout_cycles(CLK_HZ, TIMEOUT_MS);
  localparam int unsigned ICW     = $clog2(INH_CYC);
  localparam int unsigned TCW     = $clog2(TO_CYC);
  localparam int unsigned BCW     = $clog2(FRAME_BITS);

  ps2_state_e      state_q, state_d;
  logic [9:0]      shreg_q;
  logic [9:0]      shreg_shift;
  logic [BCW-1:0]  bitcnt_q;
  logic [ICW-1:0]  icnt_q;
  logic [TCW-1:0]  tcnt_q;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            clk_lvl, clk_fall;
  logic            data_lvl;
  logic            unused_data_fall;
  logic            accept;
  logic            timed_out;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
    .clk_i  (clk50),
    .rst_i  (reset),
    .line_i (ps2_clk_i),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filt (
    .clk_i  (clk50),
    .rst_i  (reset),
    .line_i (ps2_data_i),
    .level_o(data_lvl),
    .fall_o (unused_data_fall)
  );

  assign accept = (state_q == ST_IDLE) && tx_start;

  // The stop bit is not stored: shifting right fills a 1, which appears
  // at shreg[0] after the parity bit and releases the data line.
  assign shreg_shift = {1'b1, shreg_q[9:1]};

  assign timed_out = (tcnt_q == TCW'(TO_CYC - 1));

  // State register
  always_ff @(posedge clk50) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (tx_start) state_d = ST_INHIBIT;
      ST_INHIBIT: if (icnt_q == ICW'(INH_CYC - 1)) state_d = ST_RTS;
      ST_RTS:     state_d = ST_BITS;
      ST_BITS:    if (clk_fall && (bitcnt_q == BCW'(FRAME_BITS - 1))) state_d = ST_ACK;
      ST_ACK:     if (clk_fall) state_d = data_lvl ? ST_ERR : ST_WAITREL;
      ST_WAITREL: if (clk_lvl && data_lvl) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if ((state_q inside {ST_INHIBIT, ST_RTS, ST_BITS, ST_ACK, ST_WAITREL}) && timed_out)
      state_d = ST_ERR;
  end

  // Output logic; line enables are computed from the next state and registered
  always_comb begin
    clk_oe_d  = (state_d == ST_INHIBIT);
    data_oe_d = 1'b0;
    unique case (state_d)
      ST_RTS:  data_oe_d = 1'b1;
      ST_BITS: data_oe_d = (state_q == ST_BITS && clk_fall) ? ~shreg_shift[0] : data_oe_q;
      default: data_oe_d = 1'b0;
    endcase
    tx_busy = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    tx_done = (state_q == ST_DONE);
    tx_err  = (state_q == ST_ERR);
  end

  // Datapath: shift register, counters, registered line enables
  always_ff @(posedge clk50) begin
    if (reset) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      icnt_q    <= '0;
      tcnt_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      if (accept) begin
        shreg_q  <= {~^tx_data, tx_data, 1'b0};
        bitcnt_q <= '0;
        icnt_q   <= '0;
        tcnt_q   <= '0;
      end else begin
        if (state_q != ST_IDLE)    tcnt_q <= tcnt_q + 1'b1;
        if (state_q == ST_INHIBIT) icnt_q <= icnt_q + 1'b1;
        if (state_q == ST_BITS && clk_fall) begin
          shreg_q  <= shreg_shift;
          bitcnt_q <= bitcnt_q + 1'b1;
        end
      end
    end
  end

  assign rx_hold     = tx_busy;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: open-collector bus plus a keyboard model clocking at
// 12.5 kHz against a scaled clock (2 MHz nominal: 200-cycle inhibit,
// 10000-cycle timeout, 160-cycle PS/2 bit period).
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ     = 2_000_000;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TIMEOUT_MS = 5;
  localparam int unsigned FILTER     = 8;
  localparam int unsigned INH_CYC    = 200;
  localparam int unsigned TO_CYC     = 10_000;
  localparam int unsigned HALF_BIT   = 80;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_hold;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_data_low = 1'b0;
  logic       ps2_clk_bus, ps2_data_bus;

  assign ps2_clk_bus  = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_data_bus = ~(ps2_data_oe | bfm_data_low);

  always #5 clk50 = ~clk50;

  ps2_host_tx #(
    .CLK_HZ    (CLK_HZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS),
    .FILTER    (FILTER)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .rx_hold    (rx_hold),
    .ps2_clk_i  (ps2_clk_bus),
    .ps2_data_i (ps2_data_bus),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } frame_t;

  frame_t      frm_q[$];
  bit          out_q[$];   // 0 = tx_done expected, 1 = tx_err expected

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  int unsigned negcnt = 0;
  int unsigned t_busy = 0;
  int unsigned t_err = 0;
  int unsigned n_done_p = 0;
  int unsigned n_err_p = 0;
  int unsigned ovl = 0;
  int unsigned hold_bad = 0;
  int unsigned idle_drive = 0;
  logic        busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += 32'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic send(input logic [7:0] d, input bit push_frame, input bit push_out, input bit outcome);
    if (push_frame) frm_q.push_back('{data: d, par: odd_par(d)});
    if (push_out) out_q.push_back(outcome);
    @(negedge clk50);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk50);
    tx_start = 1'b0;
  endtask

  task automatic wait_out(input int unsigned limit);
    int unsigned k = 0;
    while (out_q.size() != 0 && k < limit) begin
      @(negedge clk50);
      k++;
    end
    chk("pulse_wait", 32'(out_q.size()), 32'(0));
  endtask

  // Keyboard model: times the inhibit, clocks n_pulses bits, samples data on rises.
  task automatic bfm(input int unsigned n_pulses, input bit ack);
    int unsigned w = 0;
    int unsigned low_len = 0;
    logic [10:0] bits = '0;
    logic [7:0]  mask;
    frame_t      e;
    while (ps2_clk_bus && w < 50) begin
      @(negedge clk50);
      w++;
    end
    chk("inhibit_seen", 32'(ps2_clk_bus), 32'(0));
    chk("inhibit_data_rel", 32'(ps2_data_oe), 32'(0));
    while (!ps2_clk_bus && low_len < 2000) begin
      @(negedge clk50);
      low_len++;
    end
    chk("inhibit_len_ge", 32'(low_len >= INH_CYC), 32'(1));
    chk("start_bit", 32'(ps2_data_bus), 32'(0));
    cycles(20);
    for (int i = 0; i < int'(n_pulses); i++) begin
      bfm_clk_low = 1'b1;
      cycles(HALF_BIT);
      bfm_clk_low = 1'b0;
      bits[i] = ps2_data_bus;
      cycles(20);
      if (i == 9 && ack) bfm_data_low = 1'b1;
      if (i == 10) bfm_data_low = 1'b0;
      cycles(HALF_BIT - 20);
    end
    if (frm_q.size() == 0) begin
      chk("frame_queue", 32'(frm_q.size()), 32'(1));
    end else begin
      e = frm_q.pop_front();
      if (n_pulses >= 10) begin
        chk("data_byte", 32'(bits[7:0]), 32'(e.data));
        chk("parity_bit", 32'(bits[8]), 32'(e.par));
        chk("stop_bit", 32'(bits[9]), 32'(1));
      end else begin
        mask = 8'((32'd1 << n_pulses) - 1);
        chk("partial_data", 32'(bits[7:0] & mask), 32'(e.data & mask));
      end
    end
  endtask

  // Output monitor: scoreboard pop on each completion pulse, plus invariants
  always @(negedge clk50) begin
    negcnt++;
    if (!reset) begin
      if (tx_busy && !busy_prev) t_busy = negcnt;
      if (ps2_clk_oe && ps2_data_oe) ovl++;
      if (rx_hold !== tx_busy) hold_bad++;
      if (!tx_busy && (ps2_clk_oe || ps2_data_oe)) idle_drive++;
      if (tx_done) n_done_p++;
      if (tx_err) begin
        n_err_p++;
        t_err = negcnt;
      end
      if (tx_done || tx_err) begin
        if (out_q.size() == 0) begin
          chk("unexpected_pulse", 32'({tx_done, tx_err}), 32'(0));
        end else begin
          chk("outcome", 32'(tx_err), 32'(out_q.pop_front()));
          chk("busy_at_pulse", 32'(tx_busy), 32'(0));
        end
      end
    end
    busy_prev = tx_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, e0;
    reset = 1'b1;
    cycles(5);
    chk("reset_outputs", 32'({tx_busy, tx_done, tx_err, rx_hold, ps2_clk_oe, ps2_data_oe}), 32'(0));
    reset = 1'b0;
    cycles(20);

    // 0xED with ACK
    d0 = n_done_p;
    send(8'hED, 1'b1, 1'b1, 1'b0);
    bfm(11, 1'b1);
    wait_out(500);
    chk("done_count_ed", 32'(n_done_p - d0), 32'(1));

    // parity boundaries
    send(8'h00, 1'b1, 1'b1, 1'b0);
    bfm(11, 1'b1);
    wait_out(500);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    bfm(11, 1'b1);
    wait_out(500);

    // no ACK
    d0 = n_done_p;
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    bfm(11, 1'b0);
    wait_out(500);
    chk("noack_no_done", 32'(n_done_p - d0), 32'(0));
    chk("noack_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'(0));

    // device never clocks
    send(8'h3C, 1'b0, 1'b1, 1'b1);
    wait_out(TO_CYC + 500);
    chk("timeout_cycles", 32'(t_err - t_busy), 32'(TO_CYC));
    cycles(2);
    chk("timeout_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'(0));

    // request while busy is dropped
    d0 = n_done_p;
    send(8'hF3, 1'b1, 1'b1, 1'b0);
    fork
      bfm(11, 1'b1);
      begin
        cycles(400);
        send(8'h55, 1'b0, 1'b0, 1'b0);
      end
    join
    wait_out(500);
    cycles(300);
    chk("busy_request_dropped", 32'({tx_busy, ps2_clk_oe}), 32'(0));
    chk("done_count_f3", 32'(n_done_p - d0), 32'(1));

    // reset mid-frame after D3
    d0 = n_done_p;
    e0 = n_err_p;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    bfm(4, 1'b0);
    @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    chk("midreset_outputs", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(0));
    cycles(5);
    reset = 1'b0;
    cycles(50);
    chk("midreset_no_pulse", 32'((n_done_p - d0) + (n_err_p - e0)), 32'(0));

    d0 = n_done_p;
    send(8'hFF, 1'b1, 1'b1, 1'b0);
    bfm(11, 1'b1);
    wait_out(500);
    chk("done_count_ff", 32'(n_done_p - d0), 32'(1));

    chk("oe_overlap", 32'(ovl), 32'(0));
    chk("rx_hold_eq_busy", 32'(hold_bad), 32'(0));
    chk("drive_while_idle", 32'(idle_drive), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
